// File: rtl/phase_avg_filter_if.sv
// Phase stream into the averaging filter and the smoothed result back out.
// The filter sits on the slave modport; the phase producer or bench uses master.
interface phase_avg_filter_if;
  logic [15:0] phase_in;
  logic        phase_in_vld;
  logic [15:0] phase_avg;
  logic        phase_avg_vld;
  logic        locked;
  logic [7:0]  reject_cnt;

  modport master (
    output phase_in, phase_in_vld,
    input  phase_avg, phase_avg_vld, locked, reject_cnt
  );

  modport slave (
    input  phase_in, phase_in_vld,
    output phase_avg, phase_avg_vld, locked, reject_cnt
  );
endinterface

// File: rtl/phase_avg_filter.sv
// Block-averaging phase filter with outlier rejection and lock tracking.
// Define PHASE_AVG_ROUND_EN to round the average half toward +inf instead of flooring it.
module phase_avg_filter #(
  parameter int unsigned WIN_LOG2 = 4,
  parameter int unsigned JUMP_TH  = 2000,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic                 clk_1M,
  input  logic                 rst,
  input  logic                 en,
  phase_avg_filter_if.slave    bus
);

  localparam int unsigned ACC_W  = 16 + WIN_LOG2;
  localparam int unsigned CNT_W  = WIN_LOG2 + 1;
  localparam int unsigned RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned DIFF_W = 18;
  localparam logic [CNT_W-1:0] WIN_LEN = CNT_W'(1 << WIN_LOG2);

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  state_t                   state_q, next_state;
  logic signed [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]         count_q;
  logic [RUN_W-1:0]         stable_q;
  logic [RUN_W-1:0]         run_q;
  logic                     prev_valid_q;
  logic                     locked_q;
  logic [15:0]              phase_avg_q;
  logic                     phase_avg_vld_q;
  logic [7:0]               reject_cnt_q;

  logic signed [15:0]       mag;
  logic signed [15:0]       x_val;
  logic signed [15:0]       avg_val;
  logic                     sample;
  logic                     accept;
  logic                     reject_trip;
  logic                     win_stable;
  logic [RUN_W-1:0]         stable_inc;
`ifdef PHASE_AVG_ROUND_EN
  logic signed [ACC_W-1:0]  acc_rnd;
`endif

  function automatic logic [DIFF_W-1:0] abs_diff(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
    logic signed [DIFF_W-1:0] d;
    d = DIFF_W'(a) - DIFF_W'(b);
    return d[DIFF_W-1] ? -d : d;
  endfunction

  // Next state plus sign-magnitude conversion, accept test and window average
  always_comb begin
    next_state  = state_q;
    mag         = {1'b0, bus.phase_in[14:0]};
    x_val       = bus.phase_in[15] ? -mag : mag;
`ifdef PHASE_AVG_ROUND_EN
    acc_rnd     = acc_q + ACC_W'(1 << (WIN_LOG2 - 1));
    avg_val     = 16'(acc_rnd >>> WIN_LOG2);
`else
    avg_val     = 16'(acc_q >>> WIN_LOG2);
`endif
    sample      = en && (state_q == ACCUM) && bus.phase_in_vld && (count_q != WIN_LEN);
    accept      = !locked_q || (abs_diff(x_val, $signed(phase_avg_q)) <= DIFF_W'(JUMP_TH));
    reject_trip = sample && !accept && (run_q == RUN_W'(LOCK_CNT - 1));
    win_stable  = abs_diff(avg_val, $signed(phase_avg_q)) <= DIFF_W'(JUMP_TH);
    stable_inc  = (stable_q == RUN_W'(LOCK_CNT)) ? stable_q : stable_q + 1'b1;

    case (state_q)
      IDLE:    if (en) next_state = ACCUM;
      ACCUM:   if (count_q == WIN_LEN) next_state = OUTPUT;
      OUTPUT:  next_state = ACCUM;
      default: next_state = IDLE;
    endcase
    if (!en) next_state = IDLE;
  end

  always_ff @(posedge clk_1M) begin
    if (rst) state_q <= IDLE;
    else     state_q <= next_state;
  end

  // Accumulation, output registration, reject tracking and lock qualification
  always_ff @(posedge clk_1M) begin
    if (rst) begin
      acc_q           <= '0;
      count_q         <= '0;
      stable_q        <= '0;
      run_q           <= '0;
      prev_valid_q    <= 1'b0;
      locked_q        <= 1'b0;
      phase_avg_q     <= '0;
      phase_avg_vld_q <= 1'b0;
      reject_cnt_q    <= '0;
    end else if (!en) begin
      acc_q           <= '0;
      count_q         <= '0;
      stable_q        <= '0;
      run_q           <= '0;
      prev_valid_q    <= 1'b0;
      locked_q        <= 1'b0;
      phase_avg_vld_q <= 1'b0;
    end else begin
      phase_avg_vld_q <= 1'b0;
      if (state_q == OUTPUT) begin
        acc_q   <= '0;
        count_q <= '0;
      end
      if (next_state == OUTPUT) begin
        phase_avg_q     <= avg_val;
        phase_avg_vld_q <= 1'b1;
        if (!prev_valid_q) begin
          prev_valid_q <= 1'b1;
        end else if (win_stable) begin
          stable_q <= stable_inc;
          if (stable_inc == RUN_W'(LOCK_CNT)) locked_q <= 1'b1;
        end else begin
          stable_q <= '0;
        end
      end
      if (sample) begin
        if (accept) begin
          acc_q   <= acc_q + ACC_W'(x_val);
          count_q <= count_q + 1'b1;
          run_q   <= '0;
        end else if (reject_trip) begin
          // Sustained outliers: drop lock and restart the window from scratch
          locked_q     <= 1'b0;
          stable_q     <= '0;
          prev_valid_q <= 1'b0;
          acc_q        <= '0;
          count_q      <= '0;
          run_q        <= '0;
          reject_cnt_q <= '0;
        end else begin
          run_q <= run_q + 1'b1;
          if (reject_cnt_q != 8'hFF) reject_cnt_q <= reject_cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.phase_avg     = phase_avg_q;
  assign bus.phase_avg_vld = phase_avg_vld_q;
  assign bus.locked        = locked_q;
  assign bus.reject_cnt    = reject_cnt_q;

endmodule
